// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Resolves conditional branches in EX. On a taken branch it forms the target
// (PC + immediate). An aligned target is sent to fetch as a redirect over a
// valid/ready handshake. Younger instructions are then squashed for
// FLUSH_CYCLES cycles. A misaligned target raises a one-cycle exception pulse
// and issues no redirect. Fetch predicts not-taken, so a not-taken branch
// only updates the statistics.
//
// Parameters:
//   FLUSH_CYCLES   cycles flush_out stays high after redirect acceptance (1..15)
//   COUNTER_WIDTH  width of the saturating statistics counters
//
// Ports:
//   clk                 clock, rising edge
//   reset               synchronous active-low reset
//   branch_valid_in     conditional branch present in EX (sampled in IDLE only)
//   is_branch_taken_in  comparer decision, qualified by branch_valid_in
//   branch_pc_in        PC of the branch
//   branch_imm_in       sign-extended B-type immediate
//   redirect_ready_in   fetch accepts the redirect this cycle
//   redirect_valid_out  redirect request to fetch
//   redirect_pc_out     redirect target, stable while redirect_valid_out is high
//   stall_out           hold EX and upstream stages
//   flush_out           squash IF/ID contents
//   misaligned_exc_out  one-cycle pulse: taken target not word-aligned
//   exc_pc_out          PC of the last misaligned branch
//   branch_count_out    resolved branches, saturating
//   taken_count_out     redirects issued, saturating
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     branch_valid_in,
    input  logic                     is_branch_taken_in,
    input  logic [31:0]              branch_pc_in,
    input  logic [31:0]              branch_imm_in,
    input  logic                     redirect_ready_in,
    output logic                     redirect_valid_out,
    output logic [31:0]              redirect_pc_out,
    output logic                     stall_out,
    output logic                     flush_out,
    output logic                     misaligned_exc_out,
    output logic [31:0]              exc_pc_out,
    output logic [COUNTER_WIDTH-1:0] branch_count_out,
    output logic [COUNTER_WIDTH-1:0] taken_count_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = {COUNTER_WIDTH{1'b1}};

    state_t                   state;
    state_t                   state_next;
    logic [3:0]               flush_cnt;
    logic [31:0]              redirect_pc;
    logic [31:0]              exc_pc;
    logic                     exc_pulse;
    logic [COUNTER_WIDTH-1:0] branch_count;
    logic [COUNTER_WIDTH-1:0] taken_count;

    // Target wraps modulo 2^32; the carry out is intentionally dropped.
    logic [31:0] target;
    logic        target_misaligned;
    logic        resolve;
    logic        take_aligned;
    logic        take_misaligned;

    assign target            = branch_pc_in + branch_imm_in;
    assign target_misaligned = (target[1:0] != 2'b00);
    assign resolve           = (state == IDLE) && branch_valid_in;
    assign take_aligned      = resolve && is_branch_taken_in && !target_misaligned;
    assign take_misaligned   = resolve && is_branch_taken_in && target_misaligned;

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (take_aligned)       state_next = REDIRECT;
            REDIRECT: if (redirect_ready_in)  state_next = FLUSH;
            FLUSH:    if (flush_cnt == 4'd0)  state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        redirect_valid_out = 1'b0;
        stall_out          = 1'b0;
        flush_out          = 1'b0;
        case (state)
            REDIRECT: begin
                redirect_valid_out = 1'b1;
                stall_out          = 1'b1;
                flush_out          = 1'b1;
            end
            FLUSH:    flush_out = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: target/exception capture, flush countdown, statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_cnt    <= 4'd0;
            redirect_pc  <= 32'd0;
            exc_pc       <= 32'd0;
            exc_pulse    <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            // Pulse lasts exactly one cycle after the offending branch.
            exc_pulse <= take_misaligned;

            if (take_aligned) begin
                redirect_pc <= target;
            end
            if (take_misaligned) begin
                exc_pc <= branch_pc_in;
            end

            if (state == REDIRECT && redirect_ready_in) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end

            if (resolve && branch_count != COUNT_MAX) begin
                branch_count <= branch_count + 1'b1;
            end
            if (take_aligned && taken_count != COUNT_MAX) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

    assign redirect_pc_out    = redirect_pc;
    assign exc_pc_out         = exc_pc;
    assign misaligned_exc_out = exc_pulse;
    assign branch_count_out   = branch_count;
    assign taken_count_out    = taken_count;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//
// Directed bench for branch_resolver. A default-width instance (dut) and a
// 4-bit-counter instance (dut_sat) share all inputs; the second one is only
// inspected for counter saturation. Inputs change 1 ns after the rising edge
// and outputs are sampled at the same point, so each check sees the state
// produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_valid_in;
    logic        is_branch_taken_in;
    logic [31:0] branch_pc_in;
    logic [31:0] branch_imm_in;
    logic        redirect_ready_in;

    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        stall_out;
    logic        flush_out;
    logic        misaligned_exc_out;
    logic [31:0] exc_pc_out;
    logic [31:0] branch_count_out;
    logic [31:0] taken_count_out;

    logic        s_redirect_valid_out;
    logic [31:0] s_redirect_pc_out;
    logic        s_stall_out;
    logic        s_flush_out;
    logic        s_misaligned_exc_out;
    logic [31:0] s_exc_pc_out;
    logic [3:0]  s_branch_count_out;
    logic [3:0]  s_taken_count_out;

    int total = 0;
    int bad   = 0;

    // Expected statistics for the 32-bit instance, advanced by hand per test.
    int exp_branch = 0;
    int exp_taken  = 0;

    always #5 clk = ~clk;

    branch_resolver #(.FLUSH_CYCLES(2), .COUNTER_WIDTH(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .branch_valid_in    (branch_valid_in),
        .is_branch_taken_in (is_branch_taken_in),
        .branch_pc_in       (branch_pc_in),
        .branch_imm_in      (branch_imm_in),
        .redirect_ready_in  (redirect_ready_in),
        .redirect_valid_out (redirect_valid_out),
        .redirect_pc_out    (redirect_pc_out),
        .stall_out          (stall_out),
        .flush_out          (flush_out),
        .misaligned_exc_out (misaligned_exc_out),
        .exc_pc_out         (exc_pc_out),
        .branch_count_out   (branch_count_out),
        .taken_count_out    (taken_count_out)
    );

    branch_resolver #(.FLUSH_CYCLES(2), .COUNTER_WIDTH(4)) dut_sat (
        .clk                (clk),
        .reset              (reset),
        .branch_valid_in    (branch_valid_in),
        .is_branch_taken_in (is_branch_taken_in),
        .branch_pc_in       (branch_pc_in),
        .branch_imm_in      (branch_imm_in),
        .redirect_ready_in  (redirect_ready_in),
        .redirect_valid_out (s_redirect_valid_out),
        .redirect_pc_out    (s_redirect_pc_out),
        .stall_out          (s_stall_out),
        .flush_out          (s_flush_out),
        .misaligned_exc_out (s_misaligned_exc_out),
        .exc_pc_out         (s_exc_pc_out),
        .branch_count_out   (s_branch_count_out),
        .taken_count_out    (s_taken_count_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branch_valid_in    = 1'b0;
        is_branch_taken_in = 1'b0;
        branch_pc_in       = 32'd0;
        branch_imm_in      = 32'd0;
        redirect_ready_in  = 1'b0;
    endtask

    // Flags packed as {redirect_valid, stall, flush, misaligned_exc}.
    function automatic logic [3:0] flags();
        return {redirect_valid_out, stall_out, flush_out, misaligned_exc_out};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            branch_valid_in    = 1'($urandom);
            is_branch_taken_in = 1'($urandom);
            branch_pc_in       = $urandom;
            branch_imm_in      = $urandom;
            redirect_ready_in  = 1'($urandom);
            tick();
        end
        total++;
        if (flags() !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", flags());
        end
        total++;
        if ({redirect_pc_out, exc_pc_out} !== 64'd0) begin
            bad++; $display("FAIL reset_pcs got=%h/%h want=0/0", redirect_pc_out, exc_pc_out);
        end
        total++;
        if ({branch_count_out, taken_count_out, s_branch_count_out, s_taken_count_out} !== 72'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0d want=0", branch_count_out,
                            taken_count_out, s_branch_count_out, s_taken_count_out);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        exp_branch = 0;
        exp_taken  = 0;
    endtask

    task automatic test_not_taken();
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b0;
        branch_pc_in = 32'h100; branch_imm_in = 32'h40;
        tick();
        idle_inputs();
        exp_branch++;
        total++;
        if (flags() !== 4'b0000) begin
            bad++; $display("FAIL not_taken_flags got=%b want=0000", flags());
        end
        total++;
        if (branch_count_out !== 32'(exp_branch) || taken_count_out !== 32'(exp_taken)) begin
            bad++; $display("FAIL not_taken_counts got=%0d/%0d want=%0d/%0d",
                            branch_count_out, taken_count_out, exp_branch, exp_taken);
        end
    endtask

    task automatic test_taken_ready();
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'h100; branch_imm_in = 32'hFFFF_FFF0;
        tick();
        idle_inputs();
        exp_branch++; exp_taken++;
        total++;
        if (flags() !== 4'b1110 || redirect_pc_out !== 32'h0000_00F0) begin
            bad++; $display("FAIL taken_redirect got=%b pc=%h want=1110 pc=000000f0",
                            flags(), redirect_pc_out);
        end
        redirect_ready_in = 1'b1;
        tick();
        redirect_ready_in = 1'b0;
        total++;
        if (flags() !== 4'b0010) begin
            bad++; $display("FAIL taken_flush1 got=%b want=0010", flags());
        end
        tick();
        total++;
        if (flags() !== 4'b0010) begin
            bad++; $display("FAIL taken_flush2 got=%b want=0010", flags());
        end
        tick();
        total++;
        if (flags() !== 4'b0000) begin
            bad++; $display("FAIL taken_idle got=%b want=0000", flags());
        end
        total++;
        if (branch_count_out !== 32'(exp_branch) || taken_count_out !== 32'(exp_taken)) begin
            bad++; $display("FAIL taken_counts got=%0d/%0d want=%0d/%0d",
                            branch_count_out, taken_count_out, exp_branch, exp_taken);
        end
    endtask

    task automatic test_backpressure();
        int hold_bad;
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'h200; branch_imm_in = 32'h8;
        tick();
        exp_branch++; exp_taken++;
        hold_bad = 0;
        // Branch pulses during the hold must be neither counted nor latched.
        for (int i = 0; i < 5; i++) begin
            branch_valid_in = 1'(i & 1); is_branch_taken_in = 1'b1;
            branch_pc_in = 32'h1000 + 32'(i * 16); branch_imm_in = 32'h20;
            redirect_ready_in = 1'b0;
            if (flags() !== 4'b1110 || redirect_pc_out !== 32'h208) begin
                hold_bad++;
                $display("FAIL backpressure_hold cycle=%0d got=%b pc=%h want=1110 pc=00000208",
                         i, flags(), redirect_pc_out);
            end
            tick();
        end
        total++;
        if (hold_bad != 0) bad++;
        total++;
        if (flags() !== 4'b1110 || redirect_pc_out !== 32'h208) begin
            bad++; $display("FAIL backpressure_end got=%b pc=%h want=1110 pc=00000208",
                            flags(), redirect_pc_out);
        end
        idle_inputs();
        redirect_ready_in = 1'b1;
        tick();
        // A branch offered during FLUSH is squashed and not counted.
        redirect_ready_in = 1'b0;
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'h500; branch_imm_in = 32'h4;
        total++;
        if (flags() !== 4'b0010) begin
            bad++; $display("FAIL backpressure_accept got=%b want=0010", flags());
        end
        tick();
        tick();
        idle_inputs();
        total++;
        if (flags() !== 4'b0000) begin
            bad++; $display("FAIL backpressure_idle got=%b want=0000", flags());
        end
        total++;
        if (branch_count_out !== 32'(exp_branch) || taken_count_out !== 32'(exp_taken)) begin
            bad++; $display("FAIL backpressure_counts got=%0d/%0d want=%0d/%0d",
                            branch_count_out, taken_count_out, exp_branch, exp_taken);
        end
    endtask

    task automatic test_misaligned();
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'h300; branch_imm_in = 32'h2;
        tick();
        idle_inputs();
        exp_branch++;
        total++;
        if (flags() !== 4'b0001 || exc_pc_out !== 32'h300) begin
            bad++; $display("FAIL misaligned_pulse got=%b exc_pc=%h want=0001 exc_pc=00000300",
                            flags(), exc_pc_out);
        end
        tick();
        total++;
        if (flags() !== 4'b0000 || exc_pc_out !== 32'h300) begin
            bad++; $display("FAIL misaligned_after got=%b exc_pc=%h want=0000 exc_pc=00000300",
                            flags(), exc_pc_out);
        end
        total++;
        if (branch_count_out !== 32'(exp_branch) || taken_count_out !== 32'(exp_taken)) begin
            bad++; $display("FAIL misaligned_counts got=%0d/%0d want=%0d/%0d",
                            branch_count_out, taken_count_out, exp_branch, exp_taken);
        end
    endtask

    task automatic test_wrap();
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'hFFFF_FFFC; branch_imm_in = 32'h8;
        tick();
        idle_inputs();
        exp_branch++; exp_taken++;
        total++;
        if (flags() !== 4'b1110 || redirect_pc_out !== 32'h0000_0004) begin
            bad++; $display("FAIL wrap_target got=%b pc=%h want=1110 pc=00000004",
                            flags(), redirect_pc_out);
        end
        redirect_ready_in = 1'b1;
        tick();
        redirect_ready_in = 1'b0;
        tick();
        tick();
        total++;
        if (flags() !== 4'b0000 || redirect_pc_out !== 32'h0000_0004) begin
            bad++; $display("FAIL wrap_idle got=%b pc=%h want=0000 pc=00000004",
                            flags(), redirect_pc_out);
        end
    endtask

    task automatic test_reset_mid_redirect();
        branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
        branch_pc_in = 32'h600; branch_imm_in = 32'h10;
        tick();
        idle_inputs();
        total++;
        if (flags() !== 4'b1110) begin
            bad++; $display("FAIL midreset_pre got=%b want=1110", flags());
        end
        reset = 1'b0;
        tick();
        total++;
        if (flags() !== 4'b0000 || redirect_pc_out !== 32'd0 || exc_pc_out !== 32'd0) begin
            bad++; $display("FAIL midreset_drop got=%b pc=%h exc=%h want=0000 pc=0 exc=0",
                            flags(), redirect_pc_out, exc_pc_out);
        end
        total++;
        if (branch_count_out !== 32'd0 || taken_count_out !== 32'd0) begin
            bad++; $display("FAIL midreset_counts got=%0d/%0d want=0/0",
                            branch_count_out, taken_count_out);
        end
        reset = 1'b1;
        tick();
        total++;
        if (flags() !== 4'b0000) begin
            bad++; $display("FAIL midreset_idle got=%b want=0000", flags());
        end
        exp_branch = 0;
        exp_taken  = 0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            branch_valid_in = 1'b1; is_branch_taken_in = 1'b1;
            branch_pc_in = 32'h400; branch_imm_in = 32'h4;
            tick();
            idle_inputs();
            redirect_ready_in = 1'b1;
            tick();
            redirect_ready_in = 1'b0;
            tick();
            tick();
            exp_branch++; exp_taken++;
        end
        total++;
        if (s_branch_count_out !== 4'd15 || s_taken_count_out !== 4'd15) begin
            bad++; $display("FAIL saturation_narrow got=%0d/%0d want=15/15",
                            s_branch_count_out, s_taken_count_out);
        end
        total++;
        if (branch_count_out !== 32'(exp_branch) || taken_count_out !== 32'(exp_taken)) begin
            bad++; $display("FAIL saturation_wide got=%0d/%0d want=%0d/%0d",
                            branch_count_out, taken_count_out, exp_branch, exp_taken);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_not_taken();
        test_taken_ready();
        test_backpressure();
        test_misaligned();
        test_wrap();
        test_reset_mid_redirect();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits directly downstream of the execute-stage branch comparer and consumes its taken/not-taken decision for the branch currently in EX.
- On a taken branch it computes the target (PC + immediate), checks alignment, and issues a redirect to fetch over a valid/ready handshake.
- It then squashes younger instructions for a fixed number of cycles.
- Fetch is static not-taken; not-taken branches need no action beyond statistics.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_out stays high after redirect acceptance; legal range 1..15.
- COUNTER_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- branch_valid_in  input  1  conditional branch present in EX this cycle
- is_branch_taken_in  input  1  comparer decision, qualified by branch_valid_in
- branch_pc_in  input  32  PC of the branch instruction
- branch_imm_in  input  32  sign-extended B-type immediate
- redirect_ready_in  input  1  fetch accepts redirect this cycle
- redirect_valid_out  output  1  redirect request to fetch
- redirect_pc_out  output  32  target PC; stable while redirect_valid_out is high
- stall_out  output  1  hold EX and upstream stages
- flush_out  output  1  squash IF/ID contents
- misaligned_exc_out  output  1  one-cycle pulse: taken target not word-aligned
- exc_pc_out  output  32  branch PC of the last misaligned branch
- branch_count_out  output  COUNTER_WIDTH  resolved branches, saturating
- taken_count_out  output  COUNTER_WIDTH  redirects issued, saturating

Behaviour:
- Reset (reset==0 at clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including both counters, redirect_pc_out and exc_pc_out.
  - Reset while in REDIRECT or FLUSH drops the request immediately; nothing is retained.
- Target calculation: target = branch_pc_in + branch_imm_in, modulo 2^32 with wrap-around and no overflow flag. The target is misaligned if target[1:0] != 0.
- State machine: IDLE, REDIRECT, FLUSH.
- IDLE:
  - branch_valid_in is sampled only in this state.
  - When branch_valid_in is high, branch_count_out increments.
  - Valid and not taken: no other action; stay in IDLE.
  - Valid, taken and aligned: register the target into redirect_pc_out, increment taken_count_out and go to REDIRECT. redirect_valid_out, stall_out and flush_out rise the next cycle (latency 1).
  - Valid, taken and misaligned: misaligned_exc_out pulses high for exactly the next cycle, exc_pc_out takes branch_pc_in, and the block stays in IDLE. No redirect is issued and taken_count_out does not increment.
- REDIRECT:
  - redirect_valid_out, stall_out and flush_out are all 1.
  - redirect_pc_out holds its value.
  - branch_valid_in is ignored, because EX is held on the same branch.
  - On redirect_ready_in==1: load the flush counter with FLUSH_CYCLES-1 and go to FLUSH. redirect_valid_out and stall_out fall the next cycle.
  - On redirect_ready_in==0: remain here indefinitely.
- FLUSH:
  - flush_out=1, stall_out=0, redirect_valid_out=0.
  - branch_valid_in is ignored, since instructions entering EX are squashed.
  - The counter decrements each cycle. When it reaches 0, return to IDLE on the next edge.
  - flush_out is therefore high for exactly FLUSH_CYCLES cycles after acceptance.
- redirect_ready_in is a don't-care outside REDIRECT.
- Counters saturate at 2^COUNTER_WIDTH-1 and never wrap. Each counter is independent.
- redirect_valid_out never deasserts before acceptance. redirect_pc_out never changes while redirect_valid_out is high.

Test Plan:
- Reset: drive reset=0 for 2 cycles with random inputs -> all outputs 0 and state IDLE; repeat reset in the middle of REDIRECT -> redirect_valid_out is 0 on the next cycle.
- Not-taken branch: valid=1, taken=0, pc=0x100, imm=0x40 -> no redirect, flush or exception; branch_count_out=1, taken_count_out=0.
- Taken branch, immediate ready: pc=0x100, imm=0xFFFFFFF0 ->
  - next cycle: redirect_pc_out=0x0F0 with valid, stall and flush high;
  - ready given that cycle: flush_out high 2 more cycles, then IDLE;
  - branch_count_out=1, taken_count_out=1.
- Backpressure: taken branch with pc=0x200, imm=0x8 and ready held 0 for 5 cycles -> redirect_valid_out and stall_out stay 1 with redirect_pc_out=0x208 constant; branch_valid_in pulses during the hold are not counted.
- Misaligned and wrap: pc=0x300, imm=0x2, taken -> misaligned_exc_out pulses 1 cycle, exc_pc_out=0x300, no redirect. pc=0xFFFFFFFC, imm=0x8 -> redirect_pc_out=0x00000004.
- Saturation: COUNTER_WIDTH=4 with 20 valid taken branches, each accepted -> both counters stick at 15.
